// File: rtl/spike_rate_decoder.sv
// Rate-coded readout for the RSNN output bus: counts spikes per output neuron over a
// window of enabled cycles, then reports the winning neuron, per-neuron counts and tie/silence flags.
module spike_rate_decoder #(
    parameter int NUM_OUT   = 3,
    parameter int CNT_WIDTH = 8,
    parameter int WIN_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          start,
    input  logic [WIN_WIDTH-1:0]          window_len,
    input  logic [NUM_OUT-1:0]            output_spikes,
    output logic                          busy,
    output logic                          result_valid,
    output logic [1:0]                    winner,
    output logic                          tie,
    output logic                          no_spikes,
    output logic [NUM_OUT*CNT_WIDTH-1:0]  spike_counts
);

    typedef enum logic [1:0] {IDLE, COUNT, DECIDE, REPORT} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [WIN_WIDTH-1:0] WIN_ONE = WIN_WIDTH'(1);

    state_t               state;
    logic [WIN_WIDTH-1:0] win_len;
    logic [WIN_WIDTH-1:0] win_cnt;
    logic [CNT_WIDTH-1:0] counts [NUM_OUT];

    logic [CNT_WIDTH-1:0] max_cnt;
    logic [1:0]           max_idx;
    logic [2:0]           max_hits;

    // Strict '>' keeps the lowest index when several neurons share the maximum.
    always_comb begin
        max_cnt  = counts[0];
        max_idx  = 2'd0;
        max_hits = 3'd0;
        for (int i = 1; i < NUM_OUT; i++) begin
            if (counts[i] > max_cnt) begin
                max_cnt = counts[i];
                max_idx = 2'(i);
            end
        end
        for (int i = 0; i < NUM_OUT; i++) begin
            if (counts[i] == max_cnt) max_hits = max_hits + 3'd1;
        end
    end

    // Counters are only written inside a window, so the live view freezes after DECIDE.
    for (genvar g = 0; g < NUM_OUT; g++) begin : g_pack
        assign spike_counts[g*CNT_WIDTH +: CNT_WIDTH] = counts[g];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            win_len      <= '0;
            win_cnt      <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            winner       <= 2'd0;
            tie          <= 1'b0;
            no_spikes    <= 1'b0;
            // NOTE: the counter array is reset explicitly; it is architectural state read by the host, not RAM.
            for (int i = 0; i < NUM_OUT; i++) counts[i] <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        win_len <= window_len;
                        win_cnt <= '0;
                        busy    <= 1'b1;
                        for (int i = 0; i < NUM_OUT; i++) counts[i] <= '0;
                        state   <= (window_len == '0) ? DECIDE : COUNT;
                    end
                end
                COUNT: begin
                    if (enable) begin
                        for (int i = 0; i < NUM_OUT; i++) begin
                            if (output_spikes[i] && counts[i] != CNT_MAX) counts[i] <= counts[i] + CNT_ONE;
                        end
                        win_cnt <= win_cnt + WIN_ONE;
                        if (win_cnt + WIN_ONE == win_len) state <= DECIDE;
                    end
                end
                DECIDE: begin
                    winner       <= max_idx;
                    no_spikes    <= (max_cnt == '0);
                    tie          <= (max_cnt != '0) && (max_hits > 3'd1);
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= REPORT;
                end
                REPORT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
